// File: rtl/execute_stage_pkg.sv
// Shared definitions for the light_rv32i execute stage: ALU op codes,
// forwarding select codes, branch funct3 codes and the EX/MEM register layout.
// Optional trap reporting is enabled with the LIGHT_EXEC_TRAP_EN macro.
package execute_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0,
                                  ALU_SUB   = 4'd1,
                                  ALU_SLL   = 4'd2,
                                  ALU_SLT   = 4'd3,
                                  ALU_SLTU  = 4'd4,
                                  ALU_XOR   = 4'd5,
                                  ALU_SRL   = 4'd6,
                                  ALU_SRA   = 4'd7,
                                  ALU_OR    = 4'd8,
                                  ALU_AND   = 4'd9,
                                  ALU_PASSB = 4'd10,
                                  ALU_AUIPC = 4'd11;

  localparam logic [1:0] FWD_PIPE     = 2'd0,
                         FWD_MEM      = 2'd1,
                         FWD_WB       = 2'd2,
                         FWD_PIPE_ALT = 2'd3;

  localparam logic [2:0] BR_EQ  = 3'b000,
                         BR_NE  = 3'b001,
                         BR_LT  = 3'b100,
                         BR_GE  = 3'b101,
                         BR_LTU = 3'b110,
                         BR_GEU = 3'b111;

  // EX/MEM pipeline register contents; all-zero is a bubble.
  typedef struct packed {
    logic [XLEN_DEF-1:0] target;
    logic [XLEN_DEF-1:0] result;
    logic                zero;
    logic [XLEN_DEF-1:0] reg2;
    logic [4:0]          regdst;
    logic                memtoreg;
    logic                regwren;
    logic                memwren;
    logic                branch;
    logic                jump;
`ifdef LIGHT_EXEC_TRAP_EN
    logic                trap;
`endif
  } ex_mem_t;

`ifdef LIGHT_EXEC_TRAP_EN
  // Op codes 12-15 are unassigned.
  function automatic logic is_illegal_op(input logic [ALU_OP_W-1:0] op);
    return op >= 4'd12;
  endfunction
`endif

endpackage

// File: rtl/execute_stage_alu.sv
// Purely combinational ALU for the execute stage.
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  output logic [XLEN-1:0]     result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Decode the op code; unassigned codes yield zero.
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_PASSB: result_o = b_i;
      ALU_AUIPC: result_o = pc_i + b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// light_rv32i execute stage: operand forwarding, ALU, branch compare, target
// computation and the EX/MEM pipeline registers with stall/flush.
// Define LIGHT_EXEC_TRAP_EN to add the o_pipe_Trap output.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF  // only 32 is supported
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [1:0]          i_fwd_SlctA,
  input  logic [1:0]          i_fwd_SlctB,
  input  logic [XLEN-1:0]     i_fwd_MemData,
  input  logic [XLEN-1:0]     i_fwd_WbData,
  input  logic [XLEN-1:0]     i_pipe_PC,
  input  logic [XLEN-1:0]     i_pipe_Reg1Data,
  input  logic [XLEN-1:0]     i_pipe_Reg2Data,
  input  logic [XLEN-1:0]     i_pipe_Imm,
  input  logic [ALU_OP_W-1:0] i_pipe_AluOp,
  input  logic                i_pipe_AluSrc,
  input  logic [2:0]          i_pipe_Funct3,
  input  logic                i_pipe_JumpReg,
  input  logic                i_pipe_MemToReg,
  input  logic                i_pipe_RegWrEn,
  input  logic                i_pipe_MemWrEn,
  input  logic                i_pipe_Branch,
  input  logic                i_pipe_Jump,
  input  logic [4:0]          i_pipe_RegDst,
  output logic [XLEN-1:0]     o_pipe_TargetAddr,
  output logic [XLEN-1:0]     o_pipe_AluResult,
  output logic                o_pipe_Zero,
  output logic [XLEN-1:0]     o_pipe_Reg2Data,
  output logic [4:0]          o_pipe_RegDst,
  output logic                o_pipe_MemToReg,
  output logic                o_pipe_RegWrEn,
  output logic                o_pipe_MemWrEn,
  output logic                o_pipe_Branch,
`ifdef LIGHT_EXEC_TRAP_EN
  output logic                o_pipe_Trap,
`endif
  output logic                o_pipe_Jump
);

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, jalr_sum, target;
  logic            br_cond;
  ex_mem_t         ex_new, ex_d, ex_q;

  // Forwarding muxes; codes 0 and 3 both take the decode-stage value.
  always_comb begin
    case (i_fwd_SlctA)
      FWD_MEM: op_a = i_fwd_MemData;
      FWD_WB:  op_a = i_fwd_WbData;
      default: op_a = i_pipe_Reg1Data;
    endcase
    case (i_fwd_SlctB)
      FWD_MEM: fwd_b = i_fwd_MemData;
      FWD_WB:  fwd_b = i_fwd_WbData;
      default: fwd_b = i_pipe_Reg2Data;
    endcase
    op_b = i_pipe_AluSrc ? i_pipe_Imm : fwd_b;
  end

  execute_stage_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .pc_i     (i_pipe_PC),
    .alu_op_i (i_pipe_AluOp),
    .result_o (alu_res)
  );

  // Branch compare always uses the forwarded rs2, never the immediate.
  always_comb begin
    case (i_pipe_Funct3)
      BR_EQ:   br_cond = (op_a == fwd_b);
      BR_NE:   br_cond = (op_a != fwd_b);
      BR_LT:   br_cond = ($signed(op_a) < $signed(fwd_b));
      BR_GE:   br_cond = ($signed(op_a) >= $signed(fwd_b));
      BR_LTU:  br_cond = (op_a < fwd_b);
      BR_GEU:  br_cond = (op_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  // Branch/jump target; JALR clears bit 0.
  always_comb begin
    jalr_sum = op_a + i_pipe_Imm;
    target   = i_pipe_JumpReg ? {jalr_sum[XLEN-1:1], 1'b0} : (i_pipe_PC + i_pipe_Imm);
  end

  // Assemble the value the EX/MEM register would load this cycle.
  always_comb begin
    ex_new          = '0;
    ex_new.target   = target;
    ex_new.result   = i_pipe_Jump ? (i_pipe_PC + XLEN'(4)) : alu_res;
    ex_new.zero     = br_cond & i_pipe_Branch;
    ex_new.reg2     = fwd_b;
    ex_new.regdst   = i_pipe_RegDst;
    ex_new.memtoreg = i_pipe_MemToReg;
    ex_new.regwren  = i_pipe_RegWrEn;
    ex_new.memwren  = i_pipe_MemWrEn;
    ex_new.branch   = i_pipe_Branch;
    ex_new.jump     = i_pipe_Jump;
`ifdef LIGHT_EXEC_TRAP_EN
    ex_new.trap = (is_illegal_op(i_pipe_AluOp) && i_pipe_RegWrEn) ||
                  ((ex_new.zero || i_pipe_Jump) && target[1]);
    if (ex_new.trap) begin
      ex_new.regwren = 1'b0;
      ex_new.memwren = 1'b0;
      ex_new.branch  = 1'b0;
      ex_new.jump    = 1'b0;
    end
`endif
  end

  // Flush beats stall; stall holds everything.
  always_comb begin
    ex_d = ex_q;
    if (i_flush) begin
      ex_d = '0;
    end else if (!i_stall) begin
      ex_d = ex_new;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign o_pipe_TargetAddr = ex_q.target;
  assign o_pipe_AluResult  = ex_q.result;
  assign o_pipe_Zero       = ex_q.zero;
  assign o_pipe_Reg2Data   = ex_q.reg2;
  assign o_pipe_RegDst     = ex_q.regdst;
  assign o_pipe_MemToReg   = ex_q.memtoreg;
  assign o_pipe_RegWrEn    = ex_q.regwren;
  assign o_pipe_MemWrEn    = ex_q.memwren;
  assign o_pipe_Branch     = ex_q.branch;
  assign o_pipe_Jump       = ex_q.jump;
`ifdef LIGHT_EXEC_TRAP_EN
  assign o_pipe_Trap       = ex_q.trap;
`endif

endmodule
